// File: rtl/decode_issue_unit.sv
// Fetch/decode/issue sequencer: requests one instruction at a time, decodes the
// 64-bit command word and holds it on a valid/ready handshake to the execution unit.
//
// state   | meaning
// IDLE    | waiting for start_i after reset
// REQ     | one-cycle fetch request
// WAIT    | waiting for fetch_done_i, bounded by TIMEOUT
// DECODE  | register fields, classify opcode
// ISSUE   | command presented until accepted
// HALTED  | HALT, illegal opcode or timeout; start_i resumes
module decode_issue_unit #(
  parameter int INSTR_WIDTH = 64,
  parameter int ADDR_WIDTH  = 24,
  parameter int CNT_WIDTH   = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  output logic                   fetch_en_o,
  input  logic                   fetch_done_i,
  input  logic [INSTR_WIDTH-1:0] fetch_instr_i,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [4:0]             opcode_o,
  output logic [4:0]             dest_o,
  output logic [9:0]             len_o,
  output logic [ADDR_WIDTH-1:0]  addr_o,
  output logic [4:0]             src_o,
  output logic                   busy_o,
  output logic                   halted_o,
  output logic                   illegal_o,
  output logic                   timeout_o,
  output logic [CNT_WIDTH-1:0]   retired_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_LOAD_V = 5'h01;
  localparam logic [4:0] OP_RELU   = 5'h05;
  localparam logic [4:0] OP_HALT   = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DECODE, S_ISSUE, S_HALTED
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [TW-1:0]          tmo_cnt_q;
  logic [4:0]             instr_op;

  logic latch_instr, load_fields, retire;
  logic set_illegal, set_timeout, clr_sticky;
  logic tmo_clr, tmo_inc;

  // Bits below the source field are reserved in the command format.
  logic unused_bits;
  assign unused_bits = ^instr_q[14:0];

  assign instr_op = instr_q[63:59];
  assign busy_o   = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted_o = (state_q == S_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    fetch_en_o    = 1'b0;
    issue_valid_o = 1'b0;
    latch_instr   = 1'b0;
    load_fields   = 1'b0;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_timeout   = 1'b0;
    clr_sticky    = 1'b0;
    tmo_clr       = 1'b0;
    tmo_inc       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_REQ;
      end
      S_REQ: begin
        fetch_en_o = 1'b1;
        tmo_clr    = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A fetch completing on the last allowed cycle still wins over the timeout.
        if (fetch_done_i) begin
          latch_instr = 1'b1;
          state_d     = S_DECODE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          set_timeout = 1'b1;
          state_d     = S_HALTED;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_DECODE: begin
        load_fields = 1'b1;
        if (instr_op == OP_NOP) begin
          retire  = 1'b1;
          state_d = S_REQ;
        end else if (instr_op == OP_HALT) begin
          retire  = 1'b1;
          state_d = S_HALTED;
        end else if (instr_op >= OP_LOAD_V && instr_op <= OP_RELU) begin
          state_d = S_ISSUE;
        end else begin
          set_illegal = 1'b1;
          state_d     = S_HALTED;
        end
      end
      S_ISSUE: begin
        issue_valid_o = 1'b1;
        if (issue_ready_i) begin
          retire  = 1'b1;
          state_d = S_REQ;
        end
      end
      S_HALTED: begin
        if (start_i) begin
          clr_sticky = 1'b1;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= '0;
      tmo_cnt_q <= '0;
      opcode_o  <= '0;
      dest_o    <= '0;
      len_o     <= '0;
      addr_o    <= '0;
      src_o     <= '0;
      illegal_o <= 1'b0;
      timeout_o <= 1'b0;
      retired_o <= '0;
    end else begin
      if (latch_instr) instr_q <= fetch_instr_i;
      if (tmo_clr)      tmo_cnt_q <= '0;
      else if (tmo_inc) tmo_cnt_q <= tmo_cnt_q + TW'(1);
      if (load_fields) begin
        opcode_o <= instr_q[63:59];
        dest_o   <= instr_q[58:54];
        len_o    <= instr_q[53:44];
        addr_o   <= instr_q[20 +: ADDR_WIDTH];
        src_o    <= instr_q[19:15];
      end
      if (clr_sticky) begin
        illegal_o <= 1'b0;
        timeout_o <= 1'b0;
      end else begin
        if (set_illegal) illegal_o <= 1'b1;
        if (set_timeout) timeout_o <= 1'b1;
      end
      if (retire) retired_o <= retired_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_decode_issue_unit.sv
// Directed bench for decode_issue_unit; a second narrow-counter instance
// free-runs NOPs to exercise retired-count wrap.
module tb_decode_issue_unit;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        fetch_done_i = 1'b0;
  logic [63:0] fetch_instr_i = '0;
  logic        issue_ready_i = 1'b0;
  logic        fetch_en_o, issue_valid_o, busy_o, halted_o, illegal_o, timeout_o;
  logic [4:0]  opcode_o, dest_o, src_o;
  logic [9:0]  len_o;
  logic [23:0] addr_o;
  logic [15:0] retired_o;

  logic        start_w = 1'b1;
  logic        done_w = 1'b0;
  logic        prev_w = 1'b0;
  logic        ready_w = 1'b1;
  logic [63:0] instr_w = '0;
  logic        fetch_en_w, valid_w, busy_w, halted_w, illegal_w, timeout_w;
  logic [4:0]  opcode_w, dest_w, src_w;
  logic [9:0]  len_w;
  logic [23:0] addr_w;
  logic [3:0]  retired_w;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cyc = 0;
  int issue_cnt = 0;

  always #5 clk = ~clk;

  decode_issue_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .fetch_en_o(fetch_en_o),
    .fetch_done_i(fetch_done_i), .fetch_instr_i(fetch_instr_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .opcode_o(opcode_o), .dest_o(dest_o), .len_o(len_o), .addr_o(addr_o),
    .src_o(src_o), .busy_o(busy_o), .halted_o(halted_o), .illegal_o(illegal_o),
    .timeout_o(timeout_o), .retired_o(retired_o)
  );

  decode_issue_unit #(.CNT_WIDTH(4), .TIMEOUT(TIMEOUT)) dut_w (
    .clk(clk), .rst_n(rst_n), .start_i(start_w), .fetch_en_o(fetch_en_w),
    .fetch_done_i(done_w), .fetch_instr_i(instr_w),
    .issue_valid_o(valid_w), .issue_ready_i(ready_w),
    .opcode_o(opcode_w), .dest_o(dest_w), .len_o(len_w), .addr_o(addr_w),
    .src_o(src_w), .busy_o(busy_w), .halted_o(halted_w), .illegal_o(illegal_w),
    .timeout_o(timeout_w), .retired_o(retired_w)
  );

  // Fetch stage model for the wrap instance: answer one cycle after each request.
  always @(negedge clk) begin
    done_w = prev_w;
    prev_w = fetch_en_w;
  end

  always @(posedge clk) begin
    if (issue_valid_o) valid_cyc++;
    if (issue_valid_o && issue_ready_i) issue_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Call at a negedge in REQ; returns at the negedge where the DUT sits in DECODE.
  task automatic supply(input logic [63:0] ins, input int n);
    repeat (n) @(negedge clk);
    fetch_done_i  = 1'b1;
    fetch_instr_i = ins;
    @(negedge clk);
    fetch_done_i  = 1'b0;
  endtask

  initial begin
    int v0, i0, budget;

    #12;
    check("rst_ctrl", {fetch_en_o, issue_valid_o, busy_o, halted_o, illegal_o, timeout_o}, 0);
    check("rst_fields", {opcode_o, dest_o, len_o, addr_o, src_o}, 0);
    check("rst_retired", retired_o, 0);
    @(negedge clk) rst_n = 1'b1;

    // single LOAD_V, fetch answered 9 cycles after the request
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    check("s1_fetch_en", {fetch_en_o, busy_o}, 2'b11);
    supply(64'h0A05_0000_1000_0000, 9);
    check("s1_decode_no_valid", issue_valid_o, 0);
    @(negedge clk);
    check("s1_fields", {issue_valid_o, opcode_o, dest_o, len_o, addr_o, src_o},
          {1'b1, 5'h01, 5'h08, 10'h050, 24'h000100, 5'h00});
    issue_ready_i = 1'b1;
    @(negedge clk) issue_ready_i = 1'b0;
    check("s1_retire_refetch", {retired_o, fetch_en_o, issue_valid_o}, {16'd1, 1'b1, 1'b0});

    // LOAD_M held 20+ cycles with ready low; a stray fetch_done_i must do nothing
    supply({5'd2, 5'd3, 10'h3FF, 24'hABCDEF, 5'h1F, 15'd0}, 2);
    @(negedge clk);
    for (int k = 0; k < 21; k++) begin
      check("s2_hold", {issue_valid_o, fetch_en_o, opcode_o, dest_o, len_o, addr_o, src_o},
            {1'b1, 1'b0, 5'd2, 5'd3, 10'h3FF, 24'hABCDEF, 5'h1F});
      fetch_done_i  = (k == 5);
      fetch_instr_i = (k == 5) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
      if (k < 20) @(negedge clk);
    end
    i0 = issue_cnt;
    issue_ready_i = 1'b1;
    @(negedge clk) issue_ready_i = 1'b0;
    check("s2_retire", {retired_o, fetch_en_o, issue_valid_o}, {16'd2, 1'b1, 1'b0});
    check("s2_one_handshake", issue_cnt - i0, 1);

    // NOP, GEMV, HALT stream
    i0 = issue_cnt;
    supply(64'd0, 1);
    @(negedge clk);
    check("s3_nop", {retired_o, fetch_en_o, issue_valid_o}, {16'd3, 1'b1, 1'b0});
    supply({5'd4, 5'd1, 10'd7, 24'h123456, 5'd2, 15'd0}, 1);
    @(negedge clk);
    check("s3_gemv", {issue_valid_o, opcode_o, dest_o, len_o, addr_o, src_o},
          {1'b1, 5'd4, 5'd1, 10'd7, 24'h123456, 5'd2});
    issue_ready_i = 1'b1;
    @(negedge clk) issue_ready_i = 1'b0;
    supply({5'h1F, 59'd0}, 2);
    @(negedge clk);
    check("s3_halted", {halted_o, busy_o, issue_valid_o, retired_o}, {1'b1, 1'b0, 1'b0, 16'd5});
    check("s3_issues", issue_cnt - i0, 1);

    // illegal opcode, then resume
    start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    check("s4_resume", {fetch_en_o, halted_o}, 2'b10);
    v0 = valid_cyc;
    supply({5'h10, 59'd0}, 3);
    @(negedge clk);
    check("s4_illegal", {illegal_o, halted_o, busy_o, retired_o}, {1'b1, 1'b1, 1'b0, 16'd5});
    check("s4_no_valid", valid_cyc - v0, 0);
    start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    check("s4_clear", {illegal_o, fetch_en_o}, 2'b01);

    // fetch timeout
    repeat (TIMEOUT) @(negedge clk);
    check("s5_not_yet", {timeout_o, halted_o, busy_o}, 3'b001);
    @(negedge clk);
    check("s5_timeout", {timeout_o, halted_o, busy_o, retired_o}, {1'b1, 1'b1, 1'b0, 16'd5});

    // spurious fetch_done_i in IDLE after reset
    rst_n = 1'b0;
    #1 check("s6_rst_sticky", {timeout_o, halted_o, retired_o}, 0);
    @(negedge clk) rst_n = 1'b1;
    fetch_done_i  = 1'b1;
    fetch_instr_i = {5'h1F, 59'd0};
    @(negedge clk) fetch_done_i = 1'b0;
    @(negedge clk);
    check("s6_idle_ignore", {busy_o, halted_o, fetch_en_o, retired_o}, 0);

    // reset while in ISSUE
    start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    supply({5'd1, 5'd9, 10'd33, 24'h00F00D, 5'd4, 15'd0}, 1);
    @(negedge clk);
    check("s7_issue", {issue_valid_o, opcode_o, dest_o}, {1'b1, 5'd1, 5'd9});
    issue_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("s7_rst_ctrl", {issue_valid_o, fetch_en_o, busy_o, halted_o, illegal_o, timeout_o}, 0);
    check("s7_rst_fields", {opcode_o, dest_o, len_o, addr_o, src_o, retired_o}, 0);
    @(negedge clk);
    issue_ready_i = 1'b0;
    rst_n = 1'b1;

    // retire-count wrap on the 4-bit instance
    budget = 0;
    while (retired_w != 4'hF && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("s8_reach_max", retired_w, 4'hF);
    budget = 0;
    while (retired_w == 4'hF && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check("s8_wrap", retired_w, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
